// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 32x32 register file and its write-back
// arbiter.
//   RF_AW / RF_DW : register address / data width
//   RF_NREGS      : number of architectural registers
//   RF_ZERO_REG   : index of the hard-wired zero register (writes dropped)
//   RF_NREQ       : default number of write-back producers
//   req_idx_t     : requester index type for the default producer count
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_AW       = 5;
   localparam int RF_DW       = 32;
   localparam int RF_NREGS    = 32;
   localparam int RF_ZERO_REG = 0;
   localparam int RF_NREQ     = 3;

   typedef logic [$clog2(RF_NREQ)-1:0] req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational one-hot picker. The search starts at (i_ptr+1) mod N and
// wraps, so the requester just after the pointer has highest priority.
// Tying i_ptr to N-1 gives plain fixed priority (index 0 first).
// Ports:
//   i_req [N]  : request vector
//   i_ptr [PW] : last-granted index
//   o_gnt [N]  : one-hot grant (zero when no request)
//   o_idx [PW] : binary index of the granted requester
//   o_any      : a grant was issued
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      o_gnt = '0;
      o_idx = '0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!found && i_req[j]) begin
            o_gnt[j] = 1'b1;
            o_idx    = PW'(j);
            found    = 1'b1;
         end
      end
      o_any = found;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-back arbiter for the register file's single write port. Grants at most
// one producer per cycle (valid/ready) and registers the winner onto
// w_en/write_addr/write_data/grant_id one cycle later.
// Compile-time option: RF_ARB_RR_EN defined -> round-robin arbitration with a
// last-grant pointer; undefined -> fixed priority, lowest index wins.
// Ports:
//   clk, reset (sync, active high), stall (blocks all grants)
//   req_valid/req_ready [NREQ], req_addr [NREQ*AW], req_data [NREQ*DW]
//   w_en, write_addr, write_data : register-file write port
//   pend_valid : in-flight write for hazard detection (same as w_en)
//   grant_id   : requester that produced the current output slot
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = RF_NREQ,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW,
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic                 w_en,
   output logic [AW-1:0]        write_addr,
   output logic [DW-1:0]        write_data,
   output logic                 pend_valid,
   output logic [IW-1:0]        grant_id
);

   logic [NREQ-1:0] w_req;
   logic [NREQ-1:0] w_gnt;
   logic [IW-1:0]   w_idx;
   logic [IW-1:0]   w_ptr;
   logic            w_any;
   logic [AW-1:0]   w_sel_addr;
   logic [DW-1:0]   w_sel_data;

   logic            r_wen;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_data;
   logic [IW-1:0]   r_gid;

   // Reset is folded in here so no handshake completes in a reset cycle.
   assign w_req = (stall || reset) ? '0 : req_valid;

   rr_pick #(
      .N  (NREQ),
      .PW (IW)
   ) u_pick (
      .i_req (w_req),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

`ifdef RF_ARB_RR_EN
   logic [IW-1:0] r_ptr;

   // Pointer follows every transfer, including dropped zero-register writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= IW'(NREQ - 1);
      end else if (w_any) begin
         r_ptr <= w_idx;
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = IW'(NREQ - 1);
`endif

   assign w_sel_addr = req_addr[int'(w_idx)*AW +: AW];
   assign w_sel_data = req_data[int'(w_idx)*DW +: DW];

   // Output slot: a zero-register write still completes its handshake and
   // records grant_id, but never raises the write enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wen  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_gid  <= '0;
      end else if (w_any) begin
         r_wen  <= (w_sel_addr != AW'(RF_ZERO_REG));
         r_addr <= w_sel_addr;
         r_data <= w_sel_data;
         r_gid  <= w_idx;
      end else begin
         r_wen  <= 1'b0;
      end
   end

   assign req_ready  = w_gnt;
   assign w_en       = r_wen;
   assign pend_valid = r_wen;
   assign write_addr = r_addr;
   assign write_data = r_data;
   assign grant_id   = r_gid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32). Expected
// values follow the arbitration mode selected by RF_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

`ifdef RF_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic        w_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        pend_valid;
   logic [1:0]  grant_id;

   int errors = 0;
   int checks = 0;

   regfile_wb_arbiter #(
      .NREQ (3),
      .AW   (5),
      .DW   (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .w_en       (w_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .pend_valid (pend_valid),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-requester payloads used throughout the run.
   function automatic logic [4:0] addr_of(input int i);
      case (i)
         0:       return 5'd3;
         1:       return 5'd5;
         default: return 5'd7;
      endcase
   endfunction

   function automatic logic [31:0] data_of(input int i);
      case (i)
         0:       return 32'h0000_00A0;
         1:       return 32'hDEAD_BEEF;
         default: return 32'h0000_00C2;
      endcase
   endfunction

   initial begin
      int g;
      int rr_seq [6] = '{0, 1, 2, 0, 1, 2};

      reset     = 1'b1;
      stall     = 1'b0;
      req_valid = 3'b111;
      req_addr  = {addr_of(2), addr_of(1), addr_of(0)};
      req_data  = {data_of(2), data_of(1), data_of(0)};

      // Reset held with every requester valid.
      tick();
      check("rst_ready", 64'(req_ready), 64'(3'b000));
      check("rst_wen", 64'(w_en), 64'(0));
      check("rst_pend", 64'(pend_valid), 64'(0));
      check("rst_addr", 64'(write_addr), 64'(0));
      check("rst_data", 64'(write_data), 64'(0));
      check("rst_gid", 64'(grant_id), 64'(0));
      tick();
      check("rst2_ready", 64'(req_ready), 64'(3'b000));

      // All three valid for six cycles after reset.
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         g = RR ? rr_seq[k] : 0;
         #1;
         check($sformatf("all_ready%0d", k), 64'(req_ready), 64'(3'b001 << g));
         tick();
         check($sformatf("all_wen%0d", k), 64'(w_en), 64'(1));
         check($sformatf("all_gid%0d", k), 64'(grant_id), 64'(g));
         check($sformatf("all_addr%0d", k), 64'(write_addr), 64'(addr_of(g)));
         check($sformatf("all_data%0d", k), 64'(write_data), 64'(data_of(g)));
      end

      // Idle cycle: w_en drops, address/data/id hold.
      g = RR ? 2 : 0;
      req_valid = 3'b000;
      #1;
      check("idle_ready", 64'(req_ready), 64'(0));
      tick();
      check("idle_wen", 64'(w_en), 64'(0));
      check("idle_addr_hold", 64'(write_addr), 64'(addr_of(g)));
      check("idle_gid_hold", 64'(grant_id), 64'(g));

      // Single request from requester 1.
      req_valid = 3'b010;
      #1;
      check("single_ready", 64'(req_ready), 64'(3'b010));
      tick();
      check("single_wen", 64'(w_en), 64'(1));
      check("single_pend", 64'(pend_valid), 64'(1));
      check("single_addr", 64'(write_addr), 64'(5));
      check("single_data", 64'(write_data), 64'(32'hDEAD_BEEF));
      check("single_gid", 64'(grant_id), 64'(1));

      // Zero-register write from requester 2: handshake but no enable.
      req_valid = 3'b100;
      req_addr  = {5'd0, addr_of(1), addr_of(0)};
      req_data  = {32'h0000_1234, data_of(1), data_of(0)};
      #1;
      check("zero_ready", 64'(req_ready), 64'(3'b100));
      tick();
      check("zero_wen", 64'(w_en), 64'(0));
      check("zero_pend", 64'(pend_valid), 64'(0));
      check("zero_gid", 64'(grant_id), 64'(2));

      // Pointer must now sit at 2, so requester 0 beats requester 2.
      req_addr  = {addr_of(2), addr_of(1), addr_of(0)};
      req_data  = {data_of(2), data_of(1), data_of(0)};
      req_valid = 3'b101;
      #1;
      check("ptr_adv_ready", 64'(req_ready), 64'(3'b001));
      tick();
      check("ptr_adv_gid", 64'(grant_id), 64'(0));

      // One grant, then stall for three cycles.
      g = RR ? 1 : 0;
      req_valid = 3'b111;
      #1;
      check("prestall_ready", 64'(req_ready), 64'(3'b001 << g));
      tick();
      stall = 1'b1;
      #1;
      check("stall0_ready", 64'(req_ready), 64'(0));
      check("stall0_wen", 64'(w_en), 64'(1));
      check("stall0_gid", 64'(grant_id), 64'(g));
      tick();
      check("stall1_ready", 64'(req_ready), 64'(0));
      check("stall1_wen", 64'(w_en), 64'(0));
      tick();
      check("stall2_ready", 64'(req_ready), 64'(0));
      check("stall2_wen", 64'(w_en), 64'(0));
      tick();
      stall = 1'b0;
      g = RR ? 2 : 0;
      #1;
      check("resume_ready", 64'(req_ready), 64'(3'b001 << g));
      tick();
      check("resume_wen", 64'(w_en), 64'(1));
      check("resume_gid", 64'(grant_id), 64'(g));

      // Grant requester 0, then reset: pending write cleared, pointer restored.
      #1;
      check("prereset_ready", 64'(req_ready), 64'(3'b001));
      tick();
      reset = 1'b1;
      #1;
      check("midrst_ready", 64'(req_ready), 64'(0));
      check("midrst_wen_before", 64'(w_en), 64'(1));
      tick();
      check("midrst_wen", 64'(w_en), 64'(0));
      check("midrst_pend", 64'(pend_valid), 64'(0));
      check("midrst_addr", 64'(write_addr), 64'(0));
      check("midrst_gid", 64'(grant_id), 64'(0));
      reset = 1'b0;
      #1;
      check("postrst_ready", 64'(req_ready), 64'(3'b001));
      tick();
      check("postrst_gid", 64'(grant_id), 64'(0));
      check("postrst_wen", 64'(w_en), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It accepts write requests from NREQ producers (ALU write-back, load unit, multiply/divide unit), grants at most one per cycle with valid/ready handshakes, and registers the winner onto the register file's w_en/write_addr/write_data. It also exports the in-flight write so the issue logic can detect read-after-write hazards.

## Interface
- NREQ, 3: number of requesters, 2..8.
- AW, 5: register address width.
- DW, 32: register data width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when high, no grants are issued.
- req_valid  in  NREQ  bit i: requester i holds a write.
- req_ready  out  NREQ  bit i: requester i granted this cycle (combinational).
- req_addr  in  NREQ*AW  requester i address at bits [i*AW +: AW].
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
- w_en  out  1  register-file write enable.
- write_addr  out  AW  register-file write address.
- write_data  out  DW  register-file write data.
- pend_valid  out  1  a write is in flight on w_en/write_addr this cycle (equals w_en).
- grant_id  out  $clog2(NREQ)  index of requester that produced the current w_en.

## Operation
- Transfer on requester i occurs in a cycle where req_valid[i] && req_ready[i].
- req_ready is one-hot or zero; it is zero when stall=1 or reset=1, or when no req_valid bit is set.
- req_ready[i] never depends on req_ready of the same cycle from outside; it depends only on req_valid, stall and the priority state.
- Requesters must hold valid/addr/data stable until transferred; arbiter does not buffer ungranted requests.
- Winner selection: per Configuration (round-robin or fixed priority).
- Accepted write is registered: w_en, write_addr, write_data, grant_id update on the next edge.
- Write to address 0: handshake completes normally (req_ready high), but w_en stays 0 for that slot; grant_id still updates; pend_valid=0.
- No accepted write in a cycle: w_en=0 next cycle; write_addr/write_data/grant_id hold previous values.
- Register file never back-pressures; output register accepts every cycle.

## Timing
- Reset (reset=1 at an edge): w_en=0, pend_valid=0, write_addr=0, write_data=0, grant_id=0, round-robin pointer=NREQ-1 (so requester 0 has first priority).
- Reset mid-operation: a grant in the reset cycle is not issued (req_ready=0); any w_en pending from the previous cycle is cleared at the reset edge.
- Latency: request transferred in cycle t -> w_en high in cycle t+1. Throughput: one write per cycle.
- stall rising: grants stop the same cycle; a write already registered still appears at t+1.
- Simultaneous requests: exactly one granted; others wait with valid held.

## Configuration
- RF_ARB_RR_EN defined: round-robin. Search starts at (last_grant+1) mod NREQ and wraps; pointer updates only on a transfer (including addr-0 transfers). Any continuously valid requester is granted within NREQ cycles while stall=0.
- RF_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register; starvation of higher indices is permitted.

## Structure
- Shared package regfile_pkg: AW/DW constants, register count (32), zero-register index constant, requester index type.
- One sub-module rr_pick: combinational one-hot picker from request vector and start pointer with wrap; in fixed-priority mode called with pointer tied to NREQ-1.
- Top module holds pointer register, output register, address-0 suppression.

## Test plan
- Reset with all req_valid=1 -> req_ready=0, w_en=0, write_addr=0; first cycle after reset grants requester 0.
- Single request i=1, addr=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle; next cycle w_en=1, write_addr=5, write_data=0xDEADBEEF, grant_id=1.
- All three valid for 6 cycles, RF_ARB_RR_EN defined -> grants 0,1,2,0,1,2; undefined -> grant 0 every cycle.
- Request to addr=0 with data=0x1234 -> req_ready=1, next cycle w_en=0, pend_valid=0; round-robin pointer advances.
- stall=1 for 3 cycles with requests valid -> req_ready=0 throughout; prior-cycle grant still produces w_en=1 once; grants resume on first stall=0 cycle.
- reset asserted one cycle after a grant -> w_en=0 at that edge, pointer back to NREQ-1.
